// File: rtl/act_cache_pkg.sv
// Shared constants, element/sample types and ring sizing for the activation cache.
package act_cache_pkg;

    localparam int unsigned W_DEF        = 16;
    localparam int unsigned C_DEF        = 4;
    localparam int unsigned K_DEF        = 4;
    localparam int unsigned DILATION_DEF = 16;

    typedef logic signed [W_DEF-1:0] elem_t;
    typedef elem_t [C_DEF-1:0]       sample_t;

    // Ring length needed to reach the oldest tap of a dilated kernel.
    function automatic int unsigned act_cache_depth(input int unsigned dilation,
                                                    input int unsigned k);
        return dilation * (k - 1) + 1;
    endfunction

endpackage

// File: rtl/act_cache_ring.sv
// Sample history ring: one write port, NRD read ports with registered addresses.
module act_cache_ring #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned NRD   = 3,
    parameter int unsigned AW    = 3
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [NRD-1:0][AW-1:0]   raddr_i,
    output logic [NRD-1:0][DW-1:0]   rdata_o
);

    logic [DW-1:0]           mem_q [DEPTH];
    logic [NRD-1:0][AW-1:0]  raddr_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        raddr_q <= raddr_i;
    end

    // Asynchronous read of registered addresses: a same-cycle write is not yet visible.
    always_comb begin
        rdata_o = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            rdata_o[p] = mem_q[raddr_q[p]];
        end
    end

endmodule

// File: rtl/multichannel_activation_cache.sv
// Dilated K-tap activation window over a C-channel sample stream, causal zero padding.
// Optional macro ACT_CACHE_WARMUP_GATE_EN: out_valid only once the receptive field is full.
module multichannel_activation_cache
    import act_cache_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned C        = C_DEF,
    parameter int unsigned K        = K_DEF,
    parameter int unsigned DILATION = DILATION_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           inp_valid,
    input  logic [C-1:0][W-1:0]            inp,
    output logic                           out_valid,
    output logic [K-1:0][C-1:0][W-1:0]     out
);

    localparam int unsigned DEPTH    = act_cache_depth(DILATION, K);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_MAX = (K - 1) * DILATION;
    localparam int unsigned FW       = $clog2(FILL_MAX + 1);
    localparam int unsigned SW       = C * W;

    logic [AW-1:0]               write_head_q, write_head_d;
    logic [FW-1:0]               fill_q, fill_d;
    logic                        out_valid_q, out_valid_d;
    logic [K-1:0][C-1:0][W-1:0]  out_q, out_d;

    logic                        accept_c;
    logic [AW-1:0]               addr_base_c;
    logic [AW:0]                 addr_sum_c;
    logic [K-2:0][AW-1:0]        rd_addr_c;
    logic [K-2:0][SW-1:0]        rd_data_c;

    assign accept_c  = inp_valid & ~flush;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            write_head_q <= '0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            write_head_q <= write_head_d;
            fill_q       <= fill_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        write_head_d = write_head_q;
        fill_d       = fill_q;
        out_valid_d  = 1'b0;
        out_d        = out_q;
        if (flush) begin
            write_head_d = '0;
            fill_d       = '0;
        end else if (inp_valid) begin
            write_head_d = (write_head_q == AW'(DEPTH - 1)) ? '0 : write_head_q + AW'(1);
            if (fill_q != FW'(FILL_MAX)) begin
                fill_d = fill_q + FW'(1);
            end
`ifdef ACT_CACHE_WARMUP_GATE_EN
            out_valid_d = (fill_q == FW'(FILL_MAX));
`else
            out_valid_d = 1'b1;
`endif
            out_d[K-1] = inp;
            // Taps reaching further back than the accepted history are zeroed.
            for (int unsigned j = 1; j < K; j++) begin
                out_d[K-1-j] = (32'(fill_q) >= j * DILATION) ? rd_data_c[j-1] : '0;
            end
        end
    end

    // Read addresses follow the head that will be current next cycle.
    always_comb begin
        addr_base_c = rst ? '0 : write_head_d;
        addr_sum_c  = '0;
        rd_addr_c   = '0;
        for (int unsigned j = 1; j < K; j++) begin
            if (addr_base_c >= AW'(j * DILATION)) begin
                addr_sum_c = {1'b0, addr_base_c} - (AW+1)'(j * DILATION);
            end else begin
                addr_sum_c = {1'b0, addr_base_c} + (AW+1)'(DEPTH) - (AW+1)'(j * DILATION);
            end
            rd_addr_c[j-1] = addr_sum_c[AW-1:0];
        end
    end

    act_cache_ring #(
        .DEPTH (DEPTH),
        .DW    (SW),
        .NRD   (K - 1),
        .AW    (AW)
    ) u_ring (
        .clk     (clk),
        .we_i    (accept_c),
        .waddr_i (write_head_q),
        .wdata_i (inp),
        .raddr_i (rd_addr_c),
        .rdata_o (rd_data_c)
    );

endmodule

// File: tb/tb_multichannel_activation_cache.sv
// Scoreboard bench for multichannel_activation_cache (W=16, C=2, K=4, DILATION=2).
module tb_multichannel_activation_cache;

    localparam int W = 16;
    localparam int C = 2;
    localparam int K = 4;
    localparam int D = 2;

    typedef logic [K-1:0][C-1:0][W-1:0] win_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             inp_valid = 1'b0;
    logic [C-1:0][W-1:0] inp = '0;
    logic             out_valid;
    win_t             out;

    int   hist[$];
    win_t win_q[$];
    bit   m_valid = 1'b0, m_valid_n = 1'b0;
    win_t m_out = '0, m_out_n = '0;
    int   n_cmp = 0, n_bad = 0;
    bit   checking = 1'b0;

    always #5 clk = ~clk;

    multichannel_activation_cache #(.W(W), .C(C), .K(K), .DILATION(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .inp_valid (inp_valid),
        .inp       (inp),
        .out_valid (out_valid),
        .out       (out)
    );

    always @(posedge clk) begin
        m_valid <= m_valid_n;
        m_out   <= m_out_n;
    end

    // ch0 values for out[0..3]; ch1 always carries the negated value.
    function automatic win_t mk(input int a0, input int a1, input int a2, input int a3);
        win_t w;
        int   a[4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        for (int k = 0; k < K; k++) begin
            w[k][0] = 16'(a[k]);
            w[k][1] = 16'(-a[k]);
        end
        return w;
    endfunction

    task automatic step(input bit r, input bit f, input bit v, input int n,
                        input bit hand = 1'b0, input win_t hw = '0);
        win_t w;
        int   idx;
        int   val;
        rst       = r;
        flush     = f;
        inp_valid = v;
        inp[0]    = 16'(n);
        inp[1]    = 16'(-n);
        if (r) begin
            hist.delete();
            m_valid_n = 1'b0;
            m_out_n   = '0;
        end else if (f) begin
            hist.delete();
            m_valid_n = 1'b0;
        end else if (v) begin
            w[K-1][0] = 16'(n);
            w[K-1][1] = 16'(-n);
            for (int j = 1; j < K; j++) begin
                idx = hist.size() - j * D;
                val = (idx >= 0) ? hist[idx] : 0;
                w[K-1-j][0] = 16'(val);
                w[K-1-j][1] = 16'(-val);
            end
`ifdef ACT_CACHE_WARMUP_GATE_EN
            m_valid_n = (hist.size() >= (K - 1) * D);
`else
            m_valid_n = 1'b1;
`endif
            m_out_n = w;
            if (m_valid_n) win_q.push_back(hand ? hw : w);
            hist.push_back(n);
        end else begin
            m_valid_n = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: valid flag every cycle; window popped on out_valid, else out must hold.
    always @(negedge clk) begin
        if (checking) begin
            win_t e;
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_bad++;
                $display("FAIL valid @%0t: got %0b want %0b", $time, out_valid, m_valid);
            end
            if (out_valid) begin
                n_cmp++;
                if (win_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_window @%0t: got %h want none", $time, out);
                end else begin
                    e = win_q.pop_front();
                    if (out !== e) begin
                        n_bad++;
                        $display("FAIL window @%0t: got %h want %h", $time, out, e);
                    end
                end
            end else begin
                n_cmp++;
                if (out !== m_out) begin
                    n_bad++;
                    $display("FAIL hold @%0t: got %h want %h", $time, out, m_out);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checking = 1'b1;
        step(0, 0, 0, 0);

        for (int n = 1; n <= 10; n++) step(0, 0, 1, n, n == 7, mk(1, 3, 5, 7));
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 2);
        step(0, 0, 1, 3, 1'b1, mk(0, 0, 1, 3));
        for (int n = 4; n <= 8; n++) step(0, 0, 1, n);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            step(0, 0, 1, n, n == 5, mk(0, 1, 3, 5));
            step(0, 0, 0, 0);
        end

        step(1, 0, 0, 0);
        for (int n = 1; n <= 20; n++) step(0, 0, 1, n);
        step(0, 1, 1, 50);
        step(0, 0, 1, 99, 1'b1, mk(0, 0, 0, 99));
        step(0, 0, 1, 100);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        for (int n = 1; n <= 12; n++) step(0, 0, 1, n);
        step(1, 1, 1, 77);
        step(0, 0, 0, 0);
        step(0, 0, 1, 5, 1'b1, mk(0, 0, 0, 5));
        step(0, 0, 1, 6);
        step(0, 0, 1, 7);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checking = 1'b0;
        n_cmp++;
        if (win_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending windows want 0", win_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multichannel_activation_cache.md
MULTICHANNEL_ACTIVATION_CACHE -- requirements
Module: multichannel_activation_cache

Interface
REQ-001 SHALL have parameter W, default 16: width of each signed element.
REQ-002 SHALL have parameter C, default 4: channel count per sample.
REQ-003 SHALL have parameter K, default 4: kernel size (tap count), K >= 2.
REQ-004 SHALL have parameter DILATION, default 16: sample spacing between taps, >= 1.
REQ-005 SHALL have port clk  input  1: single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1: clears history without resetting the block.
REQ-008 SHALL have port inp_valid  input  1: inp carries a new sample this cycle.
REQ-009 SHALL have port inp  input  [C][W]: one signed element per channel.
REQ-010 SHALL have port out_valid  output  1: out holds a new tap window.
REQ-011 SHALL have port out  output  [K][C][W]: tap window, index K-1 newest.

Function
REQ-012 SHALL store history in a ring of DEPTH = DILATION*(K-1)+1 entries of C*W bits; DEPTH need not be a power of two.
REQ-013 SHALL advance write_head only on an accepted sample (inp_valid=1, flush=0), wrapping DEPTH-1 -> 0 by explicit compare, not by bit truncation.
REQ-014 SHALL, on an accepted sample, register out[K-1] = inp and out[K-1-j] = the sample accepted j*DILATION samples earlier, j = 1..K-1.
REQ-015 SHALL compute tap address (write_head - j*DILATION) mod DEPTH with explicit add-DEPTH on underflow.
REQ-016 SHALL have latency one cycle: out_valid asserts the cycle after an accepted sample and is low for exactly one cycle per idle input cycle.
REQ-017 SHALL hold out unchanged while no sample is accepted.
REQ-018 SHALL keep fill counter, saturating at (K-1)*DILATION, incremented per accepted sample.
REQ-019 SHALL output zero for any tap j with j*DILATION > fill (causal zero padding); stale ring contents SHALL never appear.
REQ-020 SHALL, on flush=1, zero write_head and fill and deassert out_valid next cycle; a sample presented with flush is discarded (flush wins).
REQ-021 SHALL accept back-to-back samples every cycle with no stall; no ready output exists.
REQ-022 SHALL treat ring read and write of the same address in one cycle as read-old (tap uses prior contents; j=0 taps come from inp directly).

Reset
REQ-023 SHALL, on rst=1, zero write_head, fill, out_valid and every out element on the next edge; rst overrides flush and inp_valid.
REQ-024 SHALL NOT require the ring contents to be cleared; zero padding (REQ-019) masks them.
REQ-025 SHALL, on reset asserted mid-stream, treat the first post-reset sample as the first sample ever.

Configuration
REQ-026 SHALL support macro ACT_CACHE_WARMUP_GATE_EN.
REQ-027 SHALL, with ACT_CACHE_WARMUP_GATE_EN defined, assert out_valid only for samples accepted when fill has already reached (K-1)*DILATION (full receptive field); out still updates.
REQ-028 SHALL, without the macro, assert out_valid for every accepted sample, zero-padded per REQ-019.

Structure
REQ-029 SHALL place in package act_cache_pkg: default W/C/K/DILATION constants, the sample typedef (C x W signed), and a depth function DILATION*(K-1)+1.
REQ-030 SHALL instantiate one sub-module act_cache_ring: DEPTH x (C*W) storage, one write port, K-1 registered-address read ports, inferable as distributed RAM.

Verification (W=16, C=2, K=4, DILATION=2, DEPTH=7)
REQ-031 SHALL cover: reset, then samples n=1..10 ({n,-n}) every cycle -> after sample 7 out = {1,3,5,7} ch0, {-1,-3,-5,-7} ch1, out_valid high each cycle.
REQ-032 SHALL cover: after reset, samples 1,2,3 -> after sample 3 out ch0 = {0,0,1,3}; with ACT_CACHE_WARMUP_GATE_EN out_valid stays low until the 7th sample.
REQ-033 SHALL cover: inp_valid toggling 1,0,1,0 -> out_valid 0,1,0,1 (one-cycle lag), out held on idle cycles, taps count samples not cycles.
REQ-034 SHALL cover: 20 samples (wraps ring twice), flush with inp_valid=1 -> that sample dropped, out_valid 0; next sample 99 -> out ch0 = {0,0,0,99}.
REQ-035 SHALL cover: rst pulsed mid-stream after 12 samples -> out all zero, out_valid 0; next sample 5 -> out ch0 = {0,0,0,5}, no stale data.
